// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of an asynchronous input over a fixed gate
// of GATE_CYCLES clk cycles. Gates run back-to-back while en is high. Each
// completed gate publishes its count on freq, with a one-cycle freq_valid
// pulse and a sticky overflow flag when the edge counter saturated.
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50_000_000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned      GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t           state;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             sat_flag;

    logic             sync0;
    logic             sync1;
    logic             hist;
    logic             sig_edge;

    logic [CNT_W-1:0] edge_cnt_next;
    logic             sat_flag_next;

    // Two-flop synchronizer for sig_in, plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync0 <= sig_in;
            sync1 <= sync0;
            hist  <= sync1;
        end
    end

    assign sig_edge = sync1 & ~hist;

    // Saturating edge count and sticky saturation flag including this cycle's edge
    always_comb begin
        edge_cnt_next = edge_cnt;
        sat_flag_next = sat_flag;
        if (sig_edge) begin
            if (edge_cnt == CNT_MAX) begin
                sat_flag_next = 1'b1;
            end else begin
                edge_cnt_next = edge_cnt + CNT_W'(1);
            end
        end
    end

    // Gate FSM: gate/edge counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat_flag   <= 1'b0;
            freq       <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        state    <= MEASURE;
                        busy     <= 1'b1;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                        sat_flag <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (!en) begin
                        // abandoned gate: results discarded, freq/overflow hold
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (gate_cnt == GATE_LAST) begin
                        // gate end publishes and restarts in the same cycle
                        freq       <= edge_cnt_next;
                        overflow   <= sat_flag_next;
                        freq_valid <= 1'b1;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        sat_flag   <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GW'(1);
                        edge_cnt <= edge_cnt_next;
                        sat_flag <= sat_flag_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
